// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: write-back scheduler for the register file write port.
// Arbitrates the ALU and load result producers with round-robin tie-breaking,
// registers the winning write for the register file, and keeps a busy
// scoreboard of registers that have an outstanding write, for RAW stalls.
module rf_wb_scheduler #(
    parameter int N     = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [AW-1:0]    alu_rd,
    input  logic [N-1:0]     alu_data,
    output logic             alu_ready,
    input  logic             ld_valid,
    input  logic [AW-1:0]    ld_rd,
    input  logic [N-1:0]     ld_data,
    output logic             ld_ready,
    input  logic             alloc_valid,
    input  logic [AW-1:0]    alloc_rd,
    input  logic [AW-1:0]    chk_rs1,
    input  logic [AW-1:0]    chk_rs2,
    output logic             hazard,
    output logic [DEPTH-1:0] busy_vec,
    output logic [AW-1:0]    rf_rd,
    output logic [N-1:0]     rf_write_data,
    output logic             rf_mem_write
);

    // Which requester won the most recent transfer; the other wins the next tie.
    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LD  = 1'b1
    } grant_e;

    grant_e           last_grant;
    grant_e           last_grant_next;
    logic             alu_grant;
    logic             ld_grant;
    logic             transfer;
    logic [AW-1:0]    xfer_rd;
    logic [N-1:0]     xfer_data;
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_next;

    // Arbitration: grant the single requester, or on a tie the one that did not win last.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves
        // it unassigned, which would otherwise infer a latch.
        alu_grant       = 1'b0;
        ld_grant        = 1'b0;
        last_grant_next = last_grant;
        xfer_rd         = '0;
        xfer_data       = '0;
        if (alu_valid && ld_valid) begin
            if (last_grant == GRANT_LD) alu_grant = 1'b1;
            else                        ld_grant  = 1'b1;
        end else begin
            alu_grant = alu_valid;
            ld_grant  = ld_valid;
        end
        if (alu_grant) begin
            last_grant_next = GRANT_ALU;
            xfer_rd         = alu_rd;
            xfer_data       = alu_data;
        end else if (ld_grant) begin
            last_grant_next = GRANT_LD;
            xfer_rd         = ld_rd;
            xfer_data       = ld_data;
        end
    end

    assign alu_ready = alu_grant;
    assign ld_ready  = ld_grant;
    assign transfer  = alu_grant | ld_grant;

    // Round-robin history register; reset so the ALU wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) last_grant <= GRANT_LD;
        else     last_grant <= last_grant_next;
    end

    // Write-port register: one-cycle enable pulse per accepted write, never for x0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_mem_write  <= 1'b0;
            rf_rd         <= '0;
            rf_write_data <= '0;
        end else begin
            rf_mem_write <= transfer && (xfer_rd != '0);
            if (transfer) begin
                rf_rd         <= xfer_rd;
                rf_write_data <= xfer_data;
            end
        end
    end

    // Scoreboard next state: commit clears, allocation sets and wins a collision.
    always_comb begin
        busy_next = busy_q;
        if (rf_mem_write) busy_next[rf_rd] = 1'b0;
        if (alloc_valid && (alloc_rd != '0)) busy_next[alloc_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_next;
    end

    assign busy_vec = busy_q;
    assign hazard   = busy_q[chk_rs1] | busy_q[chk_rs2];

endmodule
